// File: rtl/icb_pkg.sv
// ---------------------------------------------------------------------------
// icb_pkg
//   Shared ICB definitions: transfer-size encodings, the packed response
//   record carried through response FIFOs, and the byte-lane mask helper
//   used wherever a sized access is mapped onto a 32-bit word.
// ---------------------------------------------------------------------------
package icb_pkg;

    localparam logic [1:0] ICB_SIZE_BYTE = 2'd0;
    localparam logic [1:0] ICB_SIZE_HALF = 2'd1;
    localparam logic [1:0] ICB_SIZE_WORD = 2'd2;

    // One response beat: error flag in the MSB, read data below it.
    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } icb_rsp_t;

    // Byte lanes touched by an access of the given size at the given
    // byte offset within the word. Misaligned offsets are not rejected
    // here; the caller owns alignment checking. The illegal size yields
    // an empty mask so it can never write anything.
    function automatic logic [3:0] icb_lane_mask(input logic [1:0] size,
                                                 input logic [1:0] lane);
        logic [3:0] mask;
        mask = 4'b0000;
        case (size)
            ICB_SIZE_BYTE: mask = 4'b0001 << lane;
            ICB_SIZE_HALF: mask = lane[1] ? 4'b1100 : 4'b0011;
            ICB_SIZE_WORD: mask = 4'b1111;
            default:       mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/icb_rsp_fifo.sv
// ---------------------------------------------------------------------------
// icb_rsp_fifo
//   Small synchronous FIFO with first-word-fall-through head. The head entry
//   is visible on head_data whenever empty is low; pop retires it at the
//   next rising edge. Push and pop in the same cycle are both honoured.
//
//   Ports
//     clk        : clock, rising edge
//     rst_n      : asynchronous active-low reset (pointers/count only)
//     push       : write push_data at the tail
//     push_data  : entry to write
//     pop        : retire the head entry (ignored while empty)
//     head_data  : current head entry (undefined while empty)
//     empty      : no entries stored
//     count      : number of entries stored, 0..DEPTH
// ---------------------------------------------------------------------------
module icb_rsp_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO can still accept a push when the head leaves this cycle.
    assign do_push = push & (~full | do_pop);

    // Storage carries no reset; only the bookkeeping is cleared.
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

    assign head_data = fifo_mem[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/icb_sram_responder.sv
// ---------------------------------------------------------------------------
// icb_sram_responder
//   Memory-side ICB responder backed by a single-port SRAM of DEPTH_WORDS
//   32-bit words mapped at BASE_ADDR. Accepts one command per cycle; writes
//   update only the addressed byte lanes, reads return the whole word.
//   Responses come back strictly in order, the earliest one cycle after the
//   accept, through a response FIFO with a bypass path.
//
//   Ports
//     clk            : clock, rising edge
//     rst_n          : asynchronous active-low reset
//     icb_cmd_valid  : command valid
//     icb_cmd_ready  : command accepted when valid & ready
//     icb_cmd_addr   : byte address
//     icb_cmd_read   : 1 = read, 0 = write
//     icb_cmd_wdata  : write data, lane-aligned to addr[1:0]
//     icb_cmd_size   : 0 = byte, 1 = half, 2 = word, 3 = illegal
//     icb_rsp_valid  : response valid
//     icb_rsp_ready  : response consumed when valid & ready
//     icb_rsp_rdata  : read word (0 for writes and errors)
//     icb_rsp_err    : response carries an error
// ---------------------------------------------------------------------------
module icb_sram_responder
    import icb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          RSP_DEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        icb_cmd_valid,
    output logic        icb_cmd_ready,
    input  logic [31:0] icb_cmd_addr,
    input  logic        icb_cmd_read,
    input  logic [31:0] icb_cmd_wdata,
    input  logic [1:0]  icb_cmd_size,
    output logic        icb_rsp_valid,
    input  logic        icb_rsp_ready,
    output logic [31:0] icb_rsp_rdata,
    output logic        icb_rsp_err
);

    localparam int          IDX_W      = $clog2(DEPTH_WORDS);
    localparam int          CNT_W      = $clog2(RSP_DEPTH + 1);
    localparam logic [31:0] SPAN_BYTES = 32'(4 * DEPTH_WORDS);

    generate
        if (DEPTH_WORDS < 4 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
            $error("icb_sram_responder: DEPTH_WORDS must be a power of two >= 4");
        end
        if (RSP_DEPTH < 2) begin : g_bad_rsp_depth
            $error("icb_sram_responder: RSP_DEPTH must be >= 2");
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Command decode
    // -----------------------------------------------------------------------
    logic [31:0]      off;
    logic [IDX_W-1:0] word_idx;
    logic             addr_err;
    logic             size_err;
    logic             align_err;
    logic             cmd_err;
    logic             cmd_accept;
    logic             wr_en;
    logic             rd_en;
    logic [3:0]       lane_mask;

    // Subtracting the base lets one unsigned compare catch both ends of the
    // window: anything below BASE_ADDR wraps to a huge offset.
    assign off       = icb_cmd_addr - BASE_ADDR;
    assign word_idx  = off[IDX_W+1:2];
    assign addr_err  = (off >= SPAN_BYTES);
    assign size_err  = (icb_cmd_size == 2'd3);
    assign align_err = ((icb_cmd_size == ICB_SIZE_HALF) && icb_cmd_addr[0]) ||
                       ((icb_cmd_size == ICB_SIZE_WORD) && (icb_cmd_addr[1:0] != 2'b00));
    assign cmd_err   = addr_err | size_err | align_err;

    assign cmd_accept = icb_cmd_valid & icb_cmd_ready;
    assign wr_en      = cmd_accept & ~icb_cmd_read & ~cmd_err;
    assign rd_en      = cmd_accept &  icb_cmd_read & ~cmd_err;
    assign lane_mask  = icb_lane_mask(icb_cmd_size, icb_cmd_addr[1:0]);

    // -----------------------------------------------------------------------
    // SRAM: one byte-wide array per lane so each lane has a single writer.
    // Reads are registered. Because only one command is taken per cycle, a
    // read following a write to the same word sees the new data naturally.
    // -----------------------------------------------------------------------
    logic [31:0] rd_word;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_ram [DEPTH_WORDS];
            logic [7:0] rd_data_reg;

            always_ff @(posedge clk) begin
                if (wr_en && lane_mask[gi]) begin
                    lane_ram[word_idx] <= icb_cmd_wdata[gi*8 +: 8];
                end
                if (rd_en) begin
                    rd_data_reg <= lane_ram[word_idx];
                end
            end

            assign rd_word[gi*8 +: 8] = rd_data_reg;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Pending stage: describes the command accepted at the previous edge,
    // whose read data is now on rd_word. It always leaves this stage in the
    // next cycle, either straight to the requester or into the FIFO.
    // -----------------------------------------------------------------------
    logic     pend_valid_reg;
    logic     pend_err_reg;
    logic     pend_read_reg;
    icb_rsp_t pend_rsp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_reg <= 1'b0;
            pend_err_reg   <= 1'b0;
            pend_read_reg  <= 1'b0;
        end else begin
            pend_valid_reg <= cmd_accept;
            pend_err_reg   <= cmd_err;
            pend_read_reg  <= icb_cmd_read;
        end
    end

    always_comb begin
        pend_rsp.err   = pend_err_reg;
        pend_rsp.rdata = (pend_read_reg && !pend_err_reg) ? rd_word : 32'h0;
    end

    // -----------------------------------------------------------------------
    // Response FIFO with bypass. When the FIFO is empty the pending response
    // is presented directly; if it is consumed in that cycle it never enters
    // the FIFO. Otherwise it is queued behind any older responses.
    // -----------------------------------------------------------------------
    icb_rsp_t         fifo_head;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_push;
    logic             fifo_pop;
    logic [CNT_W-1:0] outstanding;
    icb_rsp_t         rsp_head;

    assign fifo_pop  = ~fifo_empty & icb_rsp_ready;
    assign fifo_push = pend_valid_reg & ~(fifo_empty & icb_rsp_ready);

    icb_rsp_fifo #(
        .WIDTH ($bits(icb_rsp_t)),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (pend_rsp),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        rsp_head = '0;
        if (!fifo_empty) begin
            rsp_head = fifo_head;
        end else if (pend_valid_reg) begin
            rsp_head = pend_rsp;
        end
    end

    assign icb_rsp_valid = ~fifo_empty | pend_valid_reg;
    assign icb_rsp_rdata = rsp_head.rdata;
    assign icb_rsp_err   = rsp_head.err;

    // Every accepted command is either in the pending stage or in the FIFO
    // until its response handshakes, so their sum is the outstanding count.
    // Both terms are registered, so ready never depends on this cycle's
    // rsp_ready or cmd_valid.
    assign outstanding   = fifo_count + CNT_W'(pend_valid_reg);
    assign icb_cmd_ready = rst_n & (outstanding < CNT_W'(RSP_DEPTH));

endmodule

// File: doc/icb_sram_responder.md
Name: icb_sram_responder

Overview:
- Memory-side ICB responder. It serves the command/response channels issued by the matrix-multiply accelerator's NICE memory port.
- Accepts one ICB command per cycle and performs a byte/half/word-masked write or a word read on an internal single-port SRAM array.
- Returns an in-order response through a small response FIFO.
- Used as the backing store for LHS/RHS/result matrices in block-level simulation and as the on-chip scratchpad in the integrated design.

Parameters:
- BASE_ADDR, 32'h1000_0000, byte address mapped to word 0 of the array.
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, minimum 4.
- RSP_DEPTH, 2, response FIFO entries (max outstanding commands); minimum 2.

Ports:
- clk, input, 1, sole clock; all logic rising-edge.
- rst_n, input, 1, asynchronous active-low reset.
- icb_cmd_valid, input, 1, command valid.
- icb_cmd_ready, output, 1, command accepted when valid&ready.
- icb_cmd_addr, input, 32, byte address.
- icb_cmd_read, input, 1, 1=read, 0=write.
- icb_cmd_wdata, input, 32, write data, lane-aligned to addr[1:0].
- icb_cmd_size, input, 2, 0=byte, 1=half, 2=word, 3=illegal.
- icb_rsp_valid, output, 1, response valid.
- icb_rsp_ready, input, 1, response consumed when valid&ready.
- icb_rsp_rdata, output, 32, read word (0 for writes/errors).
- icb_rsp_err, output, 1, error flag for this response.

Behaviour:
- Clocking/reset: one clock (clk); reset asynchronous, active-low (rst_n).
- Reset values:
  - icb_rsp_valid=0, icb_rsp_rdata=0, icb_rsp_err=0.
  - Response FIFO empty, outstanding count 0.
  - icb_cmd_ready=0 while rst_n low, 1 in the first cycle after release.
  - SRAM contents not reset.
- Reset mid-operation discards all in-flight responses. Writes already accepted remain in the array.
- icb_cmd_ready = (outstanding < RSP_DEPTH).
  - Outstanding increments on command accept and decrements on response handshake. Simultaneous accept and pop leaves it unchanged.
  - Ready never depends combinationally on icb_rsp_ready or icb_cmd_valid.
- Decode (combinational on accept):
  - off = icb_cmd_addr - BASE_ADDR; word index = off[31:2].
  - err = (off >= 4*DEPTH_WORDS, unsigned, address below BASE_ADDR wraps and errs) | (size==3) | (size==1 & addr[0]) | (size==2 & addr[1:0]!=0).
- Write with no error: at the accept edge, update only the selected lanes.
  - size 0: lane addr[1:0].
  - size 1: lanes {addr[1],0} and {addr[1],1}.
  - size 2: all 4 lanes.
  - Data is taken from the matching lanes of icb_cmd_wdata.
- Read with no error: synchronous SRAM read at the accept edge. The full 32-bit word is returned regardless of size.
- Error: no array access; response is rdata=0, err=1.
- Latency: a command accepted in cycle N has icb_rsp_valid=1 in cycle N+1 at the earliest. Its response is pushed into the FIFO at the N+1 edge, with a bypass so the FIFO head is visible in N+1.
- Throughput: 1 command/cycle sustained while icb_rsp_ready=1.
- Ordering: responses strictly in command order.
- Backpressure: while icb_rsp_ready=0, icb_rsp_valid/rdata/err hold stable until the handshake.
- Hazard: a read accepted in the cycle after a write to the same word returns the newly written data. One command per cycle precludes same-cycle conflicts.
- icb_rsp_valid deasserts the cycle after the last entry pops with no new push.

Decomposition:
- Shared package icb_pkg holds:
  - localparams ICB_SIZE_BYTE=2'd0, ICB_SIZE_HALF=2'd1, ICB_SIZE_WORD=2'd2.
  - A function producing the 4-bit lane mask from size and addr[1:0].
- Sub-module icb_rsp_fifo: parameterised width (33 bits: err+rdata) and depth. Push/pop, count output, first-word-fall-through head. Used by this block and reusable by the accelerator's request side.

Test Plan:
- Reset release → cmd_ready=1, rsp_valid=0. Write word 0xDEADBEEF to BASE_ADDR+0x10, then read it back → read rsp in cycle after accept, rdata=0xDEADBEEF, err=0.
- Over that word, byte write 0xAA at +0x11 (wdata=0x0000AA00, size 0), then half write 0x1234 at +0x12 (wdata=0x12340000, size 1), then word read → rdata=0x1234AAEF.
- Issue 8 back-to-back reads with rsp_ready=1 → 8 responses on consecutive cycles, cmd_ready never drops, order preserved.
- Hold rsp_ready=0 and issue 3 commands → third stalls with cmd_ready=0 after two accepts. Response fields stable. Raising rsp_ready drains in order and re-enables cmd_ready.
- Half read at +0x13, word at +0x12, size 3, and address BASE_ADDR+4*DEPTH_WORDS → each gets err=1, rdata=0. A following read shows memory unchanged.
- Pulse rst_n low with 2 responses pending → rsp_valid=0 immediately. After release cmd_ready=1; earlier accepted writes are readable.
